// File: rtl/clock_pio_pkg.sv
// Shared constants for the clock/alarm input PIO: register addresses and
// the edge / interrupt source selections.
package clock_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/clock_pio_debounce.sv
// One input bit: synchroniser chain followed by an optional stability counter
// that only accepts a new level after DEBOUNCE_CYCLES consecutive mismatches.
module clock_pio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic                   stable_q, stable_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    sync   = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb stable_d = sync;
    end else begin : g_count
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // The counter runs only while the synchronised input disagrees with stable.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync != stable_q) begin
          if (cnt_q == LAST) stable_d = sync;
          else               cnt_d    = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign stable = stable_q;

endmodule

// File: rtl/clock_pio_in_irq.sv
// Avalon-MM input PIO with debounce, W1C edge capture and level/edge interrupt,
// one instance per pushbutton/switch bank.
module clock_pio_in_irq
  import clock_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned IRQ_TYPE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_q, stable_d_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_bits, clr;
  logic             wr_en;
  logic             unused_ok;

  assign unused_ok = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    clock_pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .stable (stable[i])
    );
  end

  always_comb begin
    wr_en      = chipselect && !write_n;
    stable_d_d = stable;

    if (EDGE_TYPE == EDGE_RISING)       edge_bits = stable & ~stable_d_q;
    else if (EDGE_TYPE == EDGE_FALLING) edge_bits = ~stable & stable_d_q;
    else                                edge_bits = stable ^ stable_d_q;

    clr = '0;
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
    // OR-ing the new edge after the clear makes a same-cycle set win.
    capture_d = (capture_q & ~clr) | edge_bits;

    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_MASK) irq_mask_d = writedata[WIDTH-1:0];

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
      ADDR_MASK:    readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = capture_q;
      default:      readdata_d = '0;
    endcase

    if (IRQ_TYPE == IRQ_LEVEL) irq = |(stable & irq_mask_q);
    else                       irq = |(capture_q & irq_mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_q <= '0;
      capture_q  <= '0;
      irq_mask_q <= '0;
      readdata_q <= '0;
    end else begin
      stable_d_q <= stable_d_d;
      capture_q  <= capture_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_clock_pio_in_irq.sv
// Directed bench for clock_pio_in_irq: four instances on a shared Avalon bus,
// each configured for one family of behaviours.
module tb_clock_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;

  logic [7:0]  in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [31:0] rd_a, rd_b, rd_c, rd_d;
  logic        irq_a, irq_b, irq_c, irq_d;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // a: plain edge irq; b: debounced; c: level irq; d: any-edge capture
  clock_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));
  clock_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));
  clock_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));
  clock_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_d), .in_port(in_d), .irq(irq_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Bus tasks are entered and left on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a;
    @(negedge clk);
  endtask

  initial begin
    // Reset
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_irq_a", {31'b0, irq_a}, 32'h0);
    check("rst_irq_b", {31'b0, irq_b}, 32'h0);
    check("rst_irq_c", {31'b0, irq_c}, 32'h0);
    check("rst_irq_d", {31'b0, irq_d}, 32'h0);
    check("rst_rd_a", rd_a, 32'h0);
    reset_n = 1'b1;
    bus_read(3'd0); check("rst_data", rd_a, 32'h0);
    bus_read(3'd2); check("rst_mask", rd_a, 32'h0);
    bus_read(3'd3); check("rst_edgecap", rd_a, 32'h0);

    // Rising edge to irq latency, then W1C
    bus_write(3'd2, 32'h01);
    bus_read(3'd2); check("mask_rb", rd_a, 32'h01);
    in_a = 8'h01;
    repeat (3) @(negedge clk);
    check("irq_early", {31'b0, irq_a}, 32'h0);
    @(negedge clk);
    check("irq_4clk", {31'b0, irq_a}, 32'h1);
    bus_read(3'd3); check("edgecap_b0", rd_a, 32'h01);
    check("irq_held", {31'b0, irq_a}, 32'h1);
    bus_write(3'd3, 32'h01);
    check("irq_w1c", {31'b0, irq_a}, 32'h0);

    // Edge and clear on bit 5 in the same cycle
    in_a = 8'h21;
    repeat (3) @(negedge clk);
    bus_write(3'd3, 32'h20);
    bus_read(3'd3); check("set_wins", rd_a, 32'h20);
    bus_read(3'd0); check("data_a", rd_a, 32'h21);
    bus_write(3'd3, 32'h20);
    bus_read(3'd3); check("w1c_b5", rd_a, 32'h0);

    // Debounce N=4: short pulse rejected, long pulse accepted
    in_b = 8'h04;
    repeat (3) @(negedge clk);
    in_b = 8'h00;
    repeat (10) @(negedge clk);
    bus_read(3'd0); check("glitch_data", rd_b, 32'h0);
    bus_read(3'd3); check("glitch_cap", rd_b, 32'h0);
    in_b = 8'h04;
    repeat (6) @(negedge clk);
    in_b = 8'h00;
    bus_read(3'd0); check("pulse_data_hi", rd_b, 32'h04);
    repeat (10) @(negedge clk);
    bus_read(3'd0); check("pulse_data_lo", rd_b, 32'h0);
    bus_read(3'd3); check("pulse_cap", rd_b, 32'h04);

    // Level irq
    bus_write(3'd2, 32'h80);
    in_c = 8'h80;
    repeat (2) @(negedge clk);
    check("lvl_early", {31'b0, irq_c}, 32'h0);
    @(negedge clk);
    check("lvl_rise", {31'b0, irq_c}, 32'h1);
    repeat (5) @(negedge clk);
    check("lvl_hold", {31'b0, irq_c}, 32'h1);
    bus_write(3'd3, 32'hFF);
    check("lvl_w1c_noeff", {31'b0, irq_c}, 32'h1);
    in_c = 8'h00;
    repeat (2) @(negedge clk);
    check("lvl_fall_early", {31'b0, irq_c}, 32'h1);
    @(negedge clk);
    check("lvl_fall", {31'b0, irq_c}, 32'h0);

    // Any-edge capture while masked, then unmask
    bus_write(3'd2, 32'h00);
    in_d = 8'h08;
    repeat (2) @(negedge clk);
    in_d = 8'h00;
    repeat (8) @(negedge clk);
    check("any_masked_irq", {31'b0, irq_d}, 32'h0);
    bus_read(3'd3); check("any_cap", rd_d, 32'h08);
    bus_write(3'd2, 32'h08);
    check("unmask_irq", {31'b0, irq_d}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
